// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;
    logic              core_stall;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_a, mem_wd, mem_we,
        input  mem_rd,
        output core_stall
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_a, mem_wd, mem_we,
        output mem_rd,
        input  core_stall
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the core (m0) and a loader/DMA master (m1).
// Define ARB_ROUND_ROBIN_EN to alternate tie-breaks instead of fixed core priority.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              m0_rvalid_r;
    logic              m1_rvalid_r;
    logic [DATA_W-1:0] m0_rdata_r;
    logic [DATA_W-1:0] m1_rdata_r;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              tie0_s;
    logic              at_max_s;
    logic [ADDR_W-1:0] mem_a_s;
    logic [DATA_W-1:0] mem_wd_s;
    logic              mem_we_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_r;
`endif

    function automatic logic [3:0] cnt_inc(input logic [3:0] c);
        return (c < MAX_CNT) ? c + 4'd1 : c;
    endfunction

    assign at_max_s = (cnt_r == MAX_CNT);

    // Tie-break preference for m0 when both ports request.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        tie0_s = last_r;
`else
        tie0_s = 1'b1;
`endif
    end

    // Grant selection: locked loader ownership, then contention, then single requester.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if ((state_r == OWN1) && bus.m1_lock && bus.m1_req) begin
            // The burst limit still lets a waiting core break a loader lock.
            if (bus.m0_req && at_max_s) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.m0_req && bus.m1_req) begin
            if ((state_r == OWN0) && at_max_s) begin
                gnt1_s = 1'b1;
            end else if (tie0_s) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.m0_req) begin
            gnt0_s = 1'b1;
        end else if (bus.m1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Memory-side mux; an idle bus parks on the core address with no write data.
    always_comb begin
        mem_a_s  = bus.m0_addr;
        mem_wd_s = {DATA_W{1'b0}};
        mem_we_s = 1'b0;
        if (gnt1_s) begin
            mem_a_s  = bus.m1_addr;
            mem_wd_s = bus.m1_wdata;
            mem_we_s = bus.m1_we;
        end else if (gnt0_s) begin
            mem_a_s  = bus.m0_addr;
            mem_wd_s = bus.m0_wdata;
            mem_we_s = bus.m0_we;
        end else begin
            mem_a_s  = bus.m0_addr;
            mem_wd_s = {DATA_W{1'b0}};
            mem_we_s = 1'b0;
        end
    end

    // Ownership/burst tracking and one-cycle registered read return.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
            m0_rdata_r  <= {DATA_W{1'b0}};
            m1_rdata_r  <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_r      <= 1'b1;
`endif
        end else begin
            if (gnt0_s) begin
                state_r <= OWN0;
                cnt_r   <= (state_r == OWN0) ? cnt_inc(cnt_r) : 4'd1;
            end else if (gnt1_s) begin
                state_r <= OWN1;
                cnt_r   <= (state_r == OWN1) ? cnt_inc(cnt_r) : 4'd1;
            end else begin
                state_r <= IDLE;
                cnt_r   <= 4'd0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (gnt0_s || gnt1_s) begin
                last_r <= gnt1_s;
            end
`endif
            m0_rvalid_r <= gnt0_s & ~bus.m0_we;
            m1_rvalid_r <= gnt1_s & ~bus.m1_we;
            if (gnt0_s && !bus.m0_we) begin
                m0_rdata_r <= bus.mem_rd;
            end
            if (gnt1_s && !bus.m1_we) begin
                m1_rdata_r <= bus.mem_rd;
            end
        end
    end

    assign bus.m0_gnt     = gnt0_s;
    assign bus.m1_gnt     = gnt1_s;
    assign bus.m0_rvalid  = m0_rvalid_r;
    assign bus.m1_rvalid  = m1_rvalid_r;
    assign bus.m0_rdata   = m0_rdata_r;
    assign bus.m1_rdata   = m1_rdata_r;
    assign bus.mem_a      = mem_a_s;
    assign bus.mem_wd     = mem_wd_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.core_stall = bus.m0_req & ~gnt0_s;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench for dmem_port_arbiter with a read-return scoreboard and a small memory model.
// Expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it defined.
module tb_dmem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        rst;
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic        m1_lock;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        exp_g0;
        logic        exp_g1;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    rd_t  sb[$];
    logic [31:0] shadow [16];
    logic [31:0] mem_model [16];
    bit   loaded = 1'b0;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem_model[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem_model[bus.mem_a[5:2]] <= bus.mem_wd;
        end
    end
    assign bus.mem_rd = mem_model[bus.mem_a[5:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic q0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic q1, input logic w1, input logic lk,
                       input logic [31:0] a1, input logic [31:0] d1, input logic g0, input logic g1);
        vec_t v;
        v.rst = r; v.m0_req = q0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
        v.m1_req = q1; v.m1_we = w1; v.m1_lock = lk; v.m1_addr = a1; v.m1_wdata = d1;
        v.exp_g0 = g0; v.exp_g1 = g1;
        vecs.push_back(v);
    endtask

    task automatic idle();
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_return();
        rd_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, e.port == 1'b0});
            chk("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, e.port == 1'b1});
            if (e.port == 1'b0) chk("m0_rdata", bus.m0_rdata, e.data);
            else                chk("m1_rdata", bus.m1_rdata, e.data);
        end else begin
            chk("m0_rvalid_idle", {31'd0, bus.m0_rvalid}, 32'd0);
            chk("m1_rvalid_idle", {31'd0, bus.m1_rvalid}, 32'd0);
        end
    endtask

    task automatic apply(input vec_t v);
        rd_t         e;
        logic [31:0] exp_a;
        logic [31:0] exp_wd;
        logic        exp_we;
        rst = v.rst;
        bus.m0_req = v.m0_req; bus.m0_we = v.m0_we; bus.m0_addr = v.m0_addr; bus.m0_wdata = v.m0_wdata;
        bus.m1_req = v.m1_req; bus.m1_we = v.m1_we; bus.m1_lock = v.m1_lock;
        bus.m1_addr = v.m1_addr; bus.m1_wdata = v.m1_wdata;
        #3;
        exp_we = (v.exp_g0 & v.m0_we) | (v.exp_g1 & v.m1_we);
        exp_a  = v.exp_g1 ? v.m1_addr : v.m0_addr;
        exp_wd = v.exp_g0 ? v.m0_wdata : (v.exp_g1 ? v.m1_wdata : 32'h0);
        chk("m0_gnt", {31'd0, bus.m0_gnt}, {31'd0, v.exp_g0});
        chk("m1_gnt", {31'd0, bus.m1_gnt}, {31'd0, v.exp_g1});
        chk("core_stall", {31'd0, bus.core_stall}, {31'd0, v.m0_req & ~v.exp_g0});
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_we});
        chk("mem_a", bus.mem_a, exp_a);
        chk("mem_wd", bus.mem_wd, exp_wd);
        if (v.exp_g0 && !v.m0_we) begin
            e.port = 1'b0; e.data = shadow[v.m0_addr[5:2]]; sb.push_back(e);
        end
        if (v.exp_g1 && !v.m1_we) begin
            e.port = 1'b1; e.data = shadow[v.m1_addr[5:2]]; sb.push_back(e);
        end
        if (exp_we) shadow[exp_a[5:2]] = exp_wd;
        @(posedge clk);
        #1;
        check_return();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0;
        bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;

        // Reset with both ports requesting.
        for (int i = 0; i < 2; i++)
            add(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        // Continuous contention right after reset.
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            add(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0,
                (i % 2) == 0, (i % 2) == 1);
`else
            add(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0,
                i != 4, i == 4);
`endif
        end
        idle();
        add(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        // Locked loader write burst, then the core breaks the lock at the burst limit.
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA000_0000, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hA000_0001, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 32'hA000_0002, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hA000_0003, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hB000_0003, 1'b1, 1'b0);
        // Lock outside OWN1 has no effect.
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 1'b0, 1'b1);
        idle();
        add(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        add(1'b1, 1'b1, 1'b1, 32'h14, 32'hC0DE_0005, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1);
        idle();

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i == 1) begin
                chk("m0_rdata_reset", bus.m0_rdata, 32'h0);
                chk("m1_rdata_reset", bus.m1_rdata, 32'h0);
            end
        end

        // Reset lands while a loader read is in flight.
        rst = 1'b1;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_lock = 1'b1; bus.m1_addr = 32'h8;
        #3;
        chk("m1_gnt_pre_reset", {31'd0, bus.m1_gnt}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("m1_gnt_in_reset", {31'd0, bus.m1_gnt}, 32'd0);
        chk("mem_we_in_reset", {31'd0, bus.mem_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("m1_rvalid_after_reset", {31'd0, bus.m1_rvalid}, 32'd0);
        chk("m1_rdata_after_reset", bus.m1_rdata, 32'h0);
        begin
            vec_t v;
            v.rst = 1'b1; v.m0_req = 1'b1; v.m0_we = 1'b0; v.m0_addr = 32'h18; v.m0_wdata = 32'h0;
            v.m1_req = 1'b1; v.m1_we = 1'b0; v.m1_lock = 1'b1; v.m1_addr = 32'h8; v.m1_wdata = 32'h0;
            v.exp_g0 = 1'b1; v.exp_g1 = 1'b0;
            apply(v);
            v.m0_req = 1'b0; v.m1_req = 1'b0; v.m1_lock = 1'b0; v.exp_g0 = 1'b0;
            apply(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
